// File: rtl/lsu_mem_bridge.sv
// Load/store bridge from the execute stage to a word-organised data memory.
// Sub-word loads are extracted and extended; sub-word stores use read-modify-write.
module lsu_mem_bridge #(
  parameter int RD_WAIT = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_re,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RD   = 2'd1;
  localparam logic [1:0] WR   = 2'd2;
  localparam logic [1:0] RESP = 2'd3;
  localparam logic [15:0] WAIT_LAST = 16'(RD_WAIT);

  logic [1:0]  state_reg, state_next;
  logic        we_reg, uns_reg, err_reg;
  logic [1:0]  size_reg;
  logic [31:0] addr_reg, wdata_reg, rdata_reg;
  logic [15:0] wait_reg;

  logic        accept, misaligned, rd_last;
  logic [4:0]  lane_shift;
  logic [31:0] shifted, extended, lane_mask, merged;

  assign accept     = req_valid && (state_reg == IDLE);
  assign misaligned = (req_size == 2'b11) ||
                      (req_size == 2'b01 && req_addr[0]) ||
                      (req_size == 2'b10 && req_addr[1:0] != 2'b00);
  assign rd_last    = (state_reg == RD) && (wait_reg == WAIT_LAST);
  assign lane_shift = {addr_reg[1:0], 3'b000};
  assign shifted    = mem_rdata >> lane_shift;

  always_comb begin
    extended = shifted;
    case (size_reg)
      2'b00:   extended = uns_reg ? {24'h0, shifted[7:0]} : {{24{shifted[7]}}, shifted[7:0]};
      2'b01:   extended = uns_reg ? {16'h0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
      default: extended = shifted;
    endcase
  end

  // Accepted halfwords are 2-aligned, so lane_shift is 0 or 16 for them.
  assign lane_mask = (size_reg == 2'b00) ? (32'h0000_00FF << lane_shift)
                                         : (32'h0000_FFFF << lane_shift);
  assign merged    = (mem_rdata & ~lane_mask) | ((wdata_reg << lane_shift) & lane_mask);

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          if (misaligned)                         state_next = RESP;
          else if (req_we && req_size == 2'b10)   state_next = WR;
          else                                    state_next = RD;
        end
      end
      RD:      if (rd_last) state_next = we_reg ? WR : RESP;
      WR:      state_next = RESP;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg <= IDLE;
      we_reg    <= 1'b0;
      uns_reg   <= 1'b0;
      err_reg   <= 1'b0;
      size_reg  <= 2'b00;
      addr_reg  <= 32'h0;
      wdata_reg <= 32'h0;
      rdata_reg <= 32'h0;
      wait_reg  <= 16'h0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        we_reg    <= req_we;
        uns_reg   <= req_unsigned;
        err_reg   <= misaligned;
        size_reg  <= req_size;
        addr_reg  <= req_addr;
        wdata_reg <= req_wdata;
        rdata_reg <= 32'h0;
        wait_reg  <= 16'h0;
      end
      if (state_reg == RD) wait_reg <= wait_reg + 16'd1;
      // Last read edge: stores keep the merged word for WR, loads keep the result.
      if (rd_last) begin
        if (we_reg) wdata_reg <= merged;
        else        rdata_reg <= extended;
      end
    end
  end

  assign req_ready  = (state_reg == IDLE);
  assign resp_valid = (state_reg == RESP);
  assign resp_rdata = (state_reg == RESP) ? rdata_reg : 32'h0;
  assign resp_err   = (state_reg == RESP) && err_reg;
  assign mem_re     = (state_reg == RD);
  assign mem_we     = (state_reg == WR);
  assign mem_addr   = (state_reg == RD || state_reg == WR) ? {addr_reg[31:2], 2'b00} : 32'h0;
  assign mem_wdata  = (state_reg == WR) ? wdata_reg : 32'h0;

endmodule

// File: tb/tb_lsu_mem_bridge.sv
// Bench for lsu_mem_bridge: RD_WAIT=0 and RD_WAIT=2 instances run the same
// directed requests against private memory models and a response scoreboard.
module tb_lsu_mem_bridge;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  always #5 clk = ~clk;

  logic        req_we = 1'b0, req_unsigned = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic [31:0] req_addr = 32'h0, req_wdata = 32'h0;
  logic        v0 = 1'b0, v1 = 1'b0;

  logic        rdy0, rdy1, rv0, rv1, err0, err1, re0, re1, we0, we1;
  logic [31:0] rd0, rd1, ma0, ma1, wd0, wd1, mr0, mr1;

  logic [31:0] mem0 [0:255];
  logic [31:0] mem1 [0:255];
  logic        pl_en = 1'b0;
  logic [7:0]  pl_idx = 8'h0;
  logic [31:0] pl_data = 32'h0;

  assign mr0 = mem0[ma0[9:2]];
  assign mr1 = mem1[ma1[9:2]];
  always @(posedge clk) begin
    if (we0) mem0[ma0[9:2]] <= wd0;
    else if (pl_en) mem0[pl_idx] <= pl_data;
    if (we1) mem1[ma1[9:2]] <= wd1;
    else if (pl_en) mem1[pl_idx] <= pl_data;
  end

  lsu_mem_bridge #(.RD_WAIT(0)) dut0 (
    .clk(clk), .rst(rst), .req_valid(v0), .req_ready(rdy0), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(rv0), .resp_rdata(rd0), .resp_err(err0),
    .mem_re(re0), .mem_we(we0), .mem_addr(ma0), .mem_wdata(wd0), .mem_rdata(mr0));

  lsu_mem_bridge #(.RD_WAIT(2)) dut1 (
    .clk(clk), .rst(rst), .req_valid(v1), .req_ready(rdy1), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(rv1), .resp_rdata(rd1), .resp_err(err1),
    .mem_re(re1), .mem_we(we1), .mem_addr(ma1), .mem_wdata(wd1), .mem_rdata(mr1));

  int vectors = 0;
  int fails = 0;
  logic [32:0] q0 [$];
  logic [32:0] q1 [$];
  int re_cnt0, re_cnt1, we_cnt0, we_cnt1, rv_cnt0, rv_cnt1, acc1;
  logic [31:0] wa0, wa1, wdl0, wdl1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic pop_check(input string tag, inout logic [32:0] q [$], input logic err, input logic [31:0] rd);
    logic [32:0] e;
    vectors++;
    assert (q.size() != 0) else begin
      fails++;
      $error("FAIL %s_unexpected: observed resp_valid=1 expected no response", tag);
    end
    if (q.size() != 0) begin
      e = q.pop_front();
      check({tag, "_err"}, {31'h0, err}, {31'h0, e[32]});
      check({tag, "_rdata"}, rd, e[31:0]);
    end
  endtask

  // Per-cycle monitor: strobe counts, idle-value rules and scoreboard pops.
  initial begin
    forever begin
      @(negedge clk);
      if (re0) re_cnt0++;
      if (re1) re_cnt1++;
      if (we0) begin we_cnt0++; wa0 = ma0; wdl0 = wd0; end
      if (we1) begin we_cnt1++; wa1 = ma1; wdl1 = wd1; end
      if (re0 && we0) check("re_we_overlap0", 1, 0);
      if (re1 && we1) check("re_we_overlap1", 1, 0);
      if (!re0 && !we0) check("mem_addr_idle0", ma0, 32'h0);
      if (!re1 && !we1) check("mem_addr_idle1", ma1, 32'h0);
      if (!we0) check("mem_wdata_idle0", wd0, 32'h0);
      if (!we1) check("mem_wdata_idle1", wd1, 32'h0);
      if (!rv0) check("resp_idle0", {rd0[31:1], rd0[0] | err0}, 32'h0);
      if (!rv1) check("resp_idle1", {rd1[31:1], rd1[0] | err1}, 32'h0);
      if (rv0) begin rv_cnt0++; pop_check("resp0", q0, err0, rd0); end
      if (rv1) begin rv_cnt1++; pop_check("resp1", q1, err1, rd1); end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      if (v1 && rdy1) acc1++;
    end
  end

  task automatic preload(input logic [7:0] idx, input logic [31:0] data);
    @(negedge clk);
    pl_idx = idx; pl_data = data; pl_en = 1'b1;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready0"}, {31'h0, rdy0}, 32'h1);
    check({tag, "_ready1"}, {31'h0, rdy1}, 32'h1);
    check({tag, "_strobes"}, {26'h0, rv0, rv1, re0, re1, we0, we1}, 32'h0);
    check({tag, "_resp"}, rd0 | rd1 | {30'h0, err0, err1}, 32'h0);
    check({tag, "_mem"}, ma0 | ma1 | wd0 | wd1, 32'h0);
  endtask

  task automatic wait_ready();
    int c = 0;
    while (!(rdy0 && rdy1) && c < 50) begin @(negedge clk); c++; end
    check("ready_timeout", {31'h0, rdy0 & rdy1}, 32'h1);
  endtask

  task automatic do_req(input string tag, input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic exp_err, input logic [31:0] exp_rd, input logic [31:0] exp_wd,
                        input bit hold1);
    int lat0 = -1, lat1 = -1, k = 0;
    int n0, n1, ere0, ere1, ewe;
    if (exp_err)                     begin n0 = 1; n1 = 1; ere0 = 0; ere1 = 0; ewe = 0; end
    else if (!we)                    begin n0 = 2; n1 = 4; ere0 = 1; ere1 = 3; ewe = 0; end
    else if (size == 2'b10)          begin n0 = 2; n1 = 2; ere0 = 0; ere1 = 0; ewe = 1; end
    else                             begin n0 = 3; n1 = 5; ere0 = 1; ere1 = 3; ewe = 1; end
    @(negedge clk);
    wait_ready();
    req_we = we; req_size = size; req_unsigned = uns; req_addr = addr; req_wdata = wdata;
    v0 = 1'b1; v1 = 1'b1;
    q0.push_back({exp_err, exp_rd});
    q1.push_back({exp_err, exp_rd});
    re_cnt0 = 0; re_cnt1 = 0; we_cnt0 = 0; we_cnt1 = 0; acc1 = 0;
    wa0 = 32'h0; wa1 = 32'h0; wdl0 = 32'h0; wdl1 = 32'h0;
    @(posedge clk);
    while ((lat0 < 0 || lat1 < 0) && k < 20) begin
      k++;
      @(negedge clk);
      if (k == 1) begin
        // Fields change after acceptance; the bridge must ignore them.
        v0 = 1'b0;
        if (!hold1) v1 = 1'b0;
        req_addr = $urandom; req_wdata = $urandom; req_size = 2'($urandom_range(0, 3));
      end
      if (rv0 && lat0 < 0) lat0 = k;
      if (rv1 && lat1 < 0) begin lat1 = k; v1 = 1'b0; end
    end
    @(negedge clk);
    check({tag, "_lat0"}, 32'(lat0), 32'(n0));
    check({tag, "_lat1"}, 32'(lat1), 32'(n1));
    check({tag, "_re0"}, 32'(re_cnt0), 32'(ere0));
    check({tag, "_re1"}, 32'(re_cnt1), 32'(ere1));
    check({tag, "_we0"}, 32'(we_cnt0), 32'(ewe));
    check({tag, "_we1"}, 32'(we_cnt1), 32'(ewe));
    check({tag, "_accepts1"}, 32'(acc1), 32'h1);
    if (ewe != 0) begin
      check({tag, "_waddr0"}, wa0, {addr[31:2], 2'b00});
      check({tag, "_waddr1"}, wa1, {addr[31:2], 2'b00});
      check({tag, "_wdata0"}, wdl0, exp_wd);
      check({tag, "_wdata1"}, wdl1, exp_wd);
    end
    check({tag, "_sb_empty"}, 32'(q0.size() + q1.size()), 32'h0);
    $display("%s: we=%0d size=%0d addr=%h -> rdata0=%h lat0=%0d lat1=%0d", tag, we, size, addr, exp_rd, lat0, lat1);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin mem0[i] = 32'h0; mem1[i] = 32'h0; end
    rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b1;

    do_req("st_word",  1'b1, 2'b10, 1'b0, 32'h0800_0010, 32'hDEAD_BEEF, 1'b0, 32'h0, 32'hDEAD_BEEF, 1'b0);
    do_req("ld_word",  1'b0, 2'b10, 1'b0, 32'h0800_0010, 32'h0,         1'b0, 32'hDEAD_BEEF, 32'h0, 1'b0);
    preload(8'd8, 32'h1122_3344);
    do_req("st_byte",  1'b1, 2'b00, 1'b0, 32'h0800_0021, 32'hFFFF_FFAA, 1'b0, 32'h0, 32'h1122_AA44, 1'b0);
    do_req("ld_rmw",   1'b0, 2'b10, 1'b1, 32'h0800_0020, 32'h0,         1'b0, 32'h1122_AA44, 32'h0, 1'b0);
    preload(8'd12, 32'h0000_8000);
    do_req("ld_hs0",   1'b0, 2'b01, 1'b0, 32'h0800_0030, 32'h0, 1'b0, 32'hFFFF_8000, 32'h0, 1'b0);
    do_req("ld_hu0",   1'b0, 2'b01, 1'b1, 32'h0800_0030, 32'h0, 1'b0, 32'h0000_8000, 32'h0, 1'b0);
    do_req("ld_bs1",   1'b0, 2'b00, 1'b0, 32'h0800_0031, 32'h0, 1'b0, 32'hFFFF_FF80, 32'h0, 1'b0);
    do_req("ld_bu1",   1'b0, 2'b00, 1'b1, 32'h0800_0031, 32'h0, 1'b0, 32'h0000_0080, 32'h0, 1'b0);
    do_req("ld_hs2",   1'b0, 2'b01, 1'b0, 32'h0800_0032, 32'h0, 1'b0, 32'h0000_0000, 32'h0, 1'b0);
    do_req("st_half",  1'b1, 2'b01, 1'b0, 32'h0800_0022, 32'h1234_BEEF, 1'b0, 32'h0, 32'hBEEF_AA44, 1'b0);
    do_req("ld_bu3",   1'b0, 2'b00, 1'b1, 32'h0800_0023, 32'h0, 1'b0, 32'h0000_00BE, 32'h0, 1'b0);
    do_req("err_half", 1'b0, 2'b01, 1'b0, 32'h0800_0041, 32'h0, 1'b1, 32'h0, 32'h0, 1'b0);
    do_req("err_word", 1'b1, 2'b10, 1'b0, 32'h0800_0042, 32'h5555_5555, 1'b1, 32'h0, 32'h0, 1'b0);
    do_req("err_size", 1'b0, 2'b11, 1'b0, 32'h0800_0040, 32'h0, 1'b1, 32'h0, 32'h0, 1'b0);
    do_req("ld_hold",  1'b0, 2'b10, 1'b0, 32'h0800_0020, 32'h0, 1'b0, 32'hBEEF_AA44, 32'h0, 1'b1);

    // Reset during the RD phase of a byte read-modify-write.
    preload(8'd16, 32'h1122_3344);
    @(negedge clk);
    wait_ready();
    req_we = 1'b1; req_size = 2'b00; req_unsigned = 1'b0;
    req_addr = 32'h0800_0043; req_wdata = 32'h0000_0077;
    v0 = 1'b1; v1 = 1'b1;
    we_cnt0 = 0; we_cnt1 = 0; rv_cnt0 = 0; rv_cnt1 = 0;
    @(posedge clk);
    @(negedge clk);
    v0 = 1'b0; v1 = 1'b0;
    check("rst_mid_in_rd", {30'h0, re0, re1}, 32'h3);
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_reset_outputs("rst_mid");
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    repeat (6) @(negedge clk);
    check("rst_mid_we", 32'(we_cnt0 + we_cnt1), 32'h0);
    check("rst_mid_resp", 32'(rv_cnt0 + rv_cnt1), 32'h0);
    check("rst_mid_mem0", mem0[16], 32'h1122_3344);
    check("rst_mid_mem1", mem1[16], 32'h1122_3344);
    $display("rst_mid: byte store to %h discarded", 32'h0800_0043);

    do_req("ld_after", 1'b0, 2'b10, 1'b0, 32'h0800_0040, 32'h0, 1'b0, 32'h1122_3344, 32'h0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/lsu_mem_bridge.md
# lsu_mem_bridge

Load/store initiator that sits between the CPU execute stage and a word-organised data memory with `re`/`we`/`addr`/`data_i`/`data` semantics. It accepts one byte, halfword or word request at a time and drives the memory-side strobes. Sub-word loads are returned extracted and sign- or zero-extended. Sub-word stores are performed as read-modify-write, and misaligned requests are reported without touching memory.

## Interface
- `RD_WAIT`, 0: extra cycles `mem_re` is held before read data is sampled (0 = sample at the end of the first read cycle).
- `clk` in 1: clock.
- `rst` in 1: reset; synchronous, active-low.
- `req_valid` in 1: CPU request present.
- `req_ready` out 1: bridge idle and able to accept.
- `req_we` in 1: 1 = store, 0 = load.
- `req_size` in 2: 00 byte, 01 half, 10 word, 11 reserved.
- `req_unsigned` in 1: loads only; 1 = zero-extend, 0 = sign-extend.
- `req_addr` in 32: byte address.
- `req_wdata` in 32: store data, right-aligned (bits [7:0] for byte, [15:0] for half).
- `resp_valid` out 1: one-cycle completion pulse.
- `resp_rdata` out 32: extended load data; 0 for stores and errors.
- `resp_err` out 1: misaligned or reserved size; valid with `resp_valid`.
- `mem_re` out 1: memory read enable.
- `mem_we` out 1: memory write enable.
- `mem_addr` out 32: word-aligned address, `{req_addr[31:2],2'b00}`. No offset is subtracted; the memory owns the offset.
- `mem_wdata` out 32: full word to write.
- `mem_rdata` in 32: memory read data, valid before the rising edge while `mem_re` is high.

## Operation
- States: IDLE, RD, WR, RESP.
- `req_ready` = 1 only in IDLE.
- Acceptance: `req_valid && req_ready` at a rising edge. All `req_*` fields are latched at acceptance; later changes on them are ignored.
- Error check at acceptance:
  - half with `addr[0]`=1, word with `addr[1:0]`≠0, or size 11 → go to RESP with `err`=1.
  - No `mem_re`/`mem_we` is ever asserted for an erroring request.
- Load: IDLE → RD → RESP.
  - In RD, `mem_re`=1 for `RD_WAIT+1` cycles.
  - `mem_rdata` is sampled at the last RD edge.
- Word store: IDLE → WR → RESP.
  - In WR, `mem_we`=1 for exactly one cycle.
  - `mem_wdata` = `req_wdata`.
- Byte/half store: IDLE → RD → WR → RESP.
  - RD samples the old word.
  - WR writes the merged word: only the addressed lane is replaced, byte lane `addr[1:0]` or half lane `addr[1]`; little-endian; all other bytes are unchanged.
- Load extraction: shift `mem_rdata` right by `8*addr[1:0]`, keep 8/16/32 bits, then extend per `req_unsigned`. Word loads ignore `req_unsigned`.
- RESP lasts one cycle: `resp_valid`=1, then IDLE.
- `mem_addr` holds the latched aligned address in RD and WR and is 0 otherwise.
- `mem_wdata` is 0 outside WR.
- `mem_re` and `mem_we` are never high in the same cycle.

## Timing
- Reset (`rst`=0 at an edge) → IDLE. Outputs after reset: `req_ready`=1, `resp_valid`=0, `resp_rdata`=0, `resp_err`=0, `mem_re`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0.
- Reset mid-transaction: the transaction is discarded and no `resp_valid` is produced. A reset during RD of a read-modify-write means no write ever occurs.
- Latency, with acceptance at edge E and `resp_valid` high in the cycle after edge E+n:
  - error n=1
  - word store n=2
  - load n=2+`RD_WAIT`
  - sub-word store n=3+`RD_WAIT`
- Throughput: the next request is accepted no earlier than the RESP→IDLE edge. `req_ready` is low during RESP, so back-to-back accepts are spaced n+1 edges apart.
- `resp_rdata` and `resp_err` are driven only while `resp_valid`=1 and are 0 otherwise.

## Test plan
- Word store then load, `RD_WAIT`=0:
  - store 0xDEADBEEF to 0x08000010 → `mem_we` for 1 cycle with `mem_addr`=0x08000010 and `resp_valid` 2 cycles after accept.
  - load word from the same address → `resp_rdata`=0xDEADBEEF at n=2.
- Byte read-modify-write: memory word 0x11223344, store byte 0xAA to addr+1 → RD then WR with `mem_wdata`=0x1122AA44, `resp_valid` at n=3.
- Extension: word 0x00008000 present.
  - signed half load at +0 → 0xFFFF8000.
  - unsigned → 0x00008000.
  - signed byte at +1 → 0xFFFFFF80.
- Misalignment: half load at addr ending in 0x1, then word store at addr ending in 0x2 → `resp_err`=1, `resp_rdata`=0, n=1; `mem_re`/`mem_we` stay 0 throughout.
- Reset mid read-modify-write: assert `rst`=0 during RD of a byte store → `mem_we` never asserted, no `resp_valid`, all outputs at reset values, memory unchanged.
- `RD_WAIT`=2: load → `mem_re` high for exactly 3 cycles, `resp_valid` at n=4; `req_valid` held high during the operation is not re-accepted until IDLE.
